struct_rec_arbiter: RTL

//  Shared-record write controller: holds a 3-field record (x: 32b int, y: 1b, z: 4b)
//  and arbitrates field writes from NREQ requesters, round-robin, one write per cycle.

---
 rtl/struct_rec_arbiter_if.sv | 42 ++++
 rtl/struct_rec_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/struct_rec_arbiter_if.sv
// ----------------------------------------------------------------------------
// struct_rec_arbiter_if
//  Bundles the request handshake and record/update outputs of the shared-record
//  write controller.
//  Signals:
//   req_valid  NREQ     per-requester write request
//   req_ready  NREQ     per-requester accept (one-hot or zero)
//   req_sel    2*NREQ   field select per requester: 0=x 1=y 2=z 3=illegal
//   req_data   32*NREQ  write data per requester
//   rec_x/y/z  32/1/4   current record fields
//   upd_valid  1        a write committed on the previous edge
//   upd_id     IDW      requester index of that write
//   upd_sel    2        field select of that write
//   err_sel    1        the accepted request carried sel=3 and was dropped
//  Modports: master = requester/consumer side, slave = controller side.
// ----------------------------------------------------------------------------
interface struct_rec_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_sel;
    logic [32*NREQ-1:0] req_data;
    logic [31:0]        rec_x;
    logic               rec_y;
    logic [3:0]         rec_z;
    logic               upd_valid;
    logic [IDW-1:0]     upd_id;
    logic [1:0]         upd_sel;
    logic               err_sel;

    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, rec_x, rec_y, rec_z, upd_valid, upd_id, upd_sel, err_sel
    );

    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, rec_x, rec_y, rec_z, upd_valid, upd_id, upd_sel, err_sel
    );
endinterface

// File: rtl/struct_rec_arbiter.sv
// ----------------------------------------------------------------------------
// struct_rec_arbiter
//  Holds a 3-field record (x: 32b, y: 1b, z: 4b) and commits one field write
//  per cycle from NREQ requesters, granted round-robin over valid/ready.
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (record, pointer, FSM, outputs)
//   bus    struct_rec_arbiter_if.slave: request handshake, record fields and
//          update/error pulses
// ----------------------------------------------------------------------------
module struct_rec_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    struct_rec_arbiter_if.slave   bus
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] gnt, gnt_n;
    logic [IDW-1:0] rr, rr_n;
    logic           accept;
    logic [1:0]     sel_g;
    logic [31:0]    data_g;

    // Explicit wrap so a non-power-of-two NREQ never indexes past NREQ-1.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // First valid index at or after start, wrapping; start itself ranks first.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  start);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] pick;
        logic           found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    assign sel_g  = bus.req_sel[int'(gnt)*2 +: 2];
    assign data_g = bus.req_data[int'(gnt)*32 +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            rr    <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            rr    <= rr_n;
        end
    end

    // Ready is decoded from the registered grant, so it drops the instant
    // reset forces the FSM back to IDLE.
    always_comb begin
        state_n       = state;
        gnt_n         = gnt;
        rr_n          = rr;
        accept        = 1'b0;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    gnt_n   = rr_pick(bus.req_valid, rr);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                bus.req_ready[gnt] = 1'b1;
                if (bus.req_valid[gnt]) begin
                    accept = 1'b1;
                    rr_n   = wrap_inc(gnt);
                    // The winner's own still-high valid counts as a fresh
                    // request and is searched last.
                    gnt_n  = rr_pick(bus.req_valid, wrap_inc(gnt));
                end else begin
                    // Granted requester withdrew: no write, re-arbitrate from IDLE.
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rec_x     <= '0;
            bus.rec_y     <= 1'b0;
            bus.rec_z     <= '0;
            bus.upd_valid <= 1'b0;
            bus.upd_id    <= '0;
            bus.upd_sel   <= '0;
            bus.err_sel   <= 1'b0;
        end else begin
            bus.upd_valid <= accept;
            bus.err_sel   <= accept && (sel_g == 2'd3);
            if (accept) begin
                bus.upd_id  <= gnt;
                bus.upd_sel <= sel_g;
                case (sel_g)
                    2'd0:    bus.rec_x <= data_g;
                    2'd1:    bus.rec_y <= data_g[0];
                    2'd2:    bus.rec_z <= data_g[3:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
